// File: rtl/dsp_sequencer_if.sv
// iomem bus bundle for the DSP sequencer program RAM.
// Master drives requests, slave returns a one-cycle ready pulse.
interface dsp_sequencer_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid,
    output iomem_wstrb,
    output iomem_addr,
    output iomem_wdata,
    input  iomem_ready,
    input  iomem_rdata
  );

  modport slave (
    input  iomem_valid,
    input  iomem_wstrb,
    input  iomem_addr,
    input  iomem_wdata,
    output iomem_ready,
    output iomem_rdata
  );
endinterface

// File: rtl/dsp_sequencer.sv
// Programmable MAC sequencer: one microprogram run per audio frame,
// gain-weighted sums over a circular multi-channel sample RAM.
module dsp_sequencer #(
  parameter int          PROG_DEPTH = 64,
  parameter int          CHANNELS   = 8,
  parameter int          FRAMES     = 32,
  parameter int          SAMPLE_W   = 16,
  parameter int          ACC_W      = 40,
  parameter logic [7:0]  PROG_BASE  = 8'h60,
  localparam int         PW   = $clog2(PROG_DEPTH),
  localparam int         FR_W = $clog2(FRAMES),
  localparam int         CH_W = $clog2(CHANNELS),
  localparam int         AA_W = CH_W + FR_W
) (
  input  logic                ck,
  input  logic                rst,
  dsp_sequencer_if.slave      bus,
  input  logic                frame_start,
  input  logic [FR_W-1:0]     frame_pos,
  output logic [AA_W-1:0]     audio_addr,
  input  logic [SAMPLE_W-1:0] audio_rdata,
  output logic                out_valid,
  output logic [SAMPLE_W-1:0] out_data,
  output logic [5:0]          out_index,
  output logic                busy,
  output logic [1:0]          error
);

  localparam int PR_W = SAMPLE_W + 16;

  localparam logic [6:0] OP_MAC  = 7'b1000000;
  localparam logic [6:0] OP_MACZ = 7'b1000010;
  localparam logic [6:0] OP_SAVE = 7'b1010000;
  localparam logic [6:0] OP_HALT = 7'b1111111;

  localparam logic signed [ACC_W-1:0] SMAX =
    {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ADDR,
    S_EXEC
  } state_t;

  state_t                   state_q;
  logic [PW-1:0]            pc_q;
  logic [31:0]              instr_q;
  logic [FR_W-1:0]          pos_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     busy_q;
  logic                     ov_q;
  logic [SAMPLE_W-1:0]      od_q;
  logic [5:0]               oi_q;
  logic [5:0]               cnt_q;
  logic [1:0]               err_q;
  logic                     ready_q;
  logic [31:0]              rdata_q;
  logic [31:0]              mem_q [PROG_DEPTH];

  logic                     hit;
  logic                     bus_take;
  logic                     wr_en;
  logic [PW-1:0]            widx;
  logic [6:0]               op;
  logic signed [15:0]       gain;
  logic signed [PR_W-1:0]   prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  shr;
  logic [SAMPLE_W-1:0]      sat_d;
  logic                     is_save;
  logic                     is_halt;
  logic                     unused_bits;

  assign hit      = bus.iomem_valid &&
                    (bus.iomem_addr[31:24] == PROG_BASE);
  assign bus_take = hit && !ready_q;
  assign widx     = bus.iomem_addr[2 +: PW];
  assign wr_en    = bus_take && !rst && !busy_q &&
                    (bus.iomem_wstrb == 4'hF);

  assign op   = instr_q[31:25];
  assign gain = instr_q[15:0];

  assign audio_addr = {instr_q[16 +: CH_W],
                       pos_q - instr_q[20 +: FR_W]};

  assign unused_bits = ^{bus.iomem_addr, instr_q};

  always_comb begin
    prod     = $signed(audio_rdata) * gain;
    prod_ext = {{(ACC_W-PR_W){prod[PR_W-1]}}, prod};
    acc_d    = acc_q;
    is_save  = 1'b0;
    is_halt  = 1'b0;
    unique case (1'b1)
      op == OP_MAC:  acc_d   = acc_q + prod_ext;
      op == OP_MACZ: acc_d   = prod_ext;
      op == OP_SAVE: is_save = 1'b1;
      op == OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
    shr = acc_q >>> instr_q[5:0];
    if (shr > SMAX) begin
      sat_d = SMAX[SAMPLE_W-1:0];
    end else if (shr < SMIN) begin
      sat_d = SMIN[SAMPLE_W-1:0];
    end else begin
      sat_d = shr[SAMPLE_W-1:0];
    end
  end

  // Program RAM survives reset; only bus writes while idle land.
  always_ff @(posedge ck) begin
    if (wr_en) begin
      mem_q[widx] <= bus.iomem_wdata;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= bus_take;
      if (bus_take) begin
        rdata_q <= mem_q[widx];
      end
    end
  end

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      pos_q   <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      oi_q    <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      ov_q <= 1'b0;
      if (frame_start && busy_q) begin
        err_q[0] <= 1'b1;
      end
      unique case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            pos_q   <= frame_pos;
            pc_q    <= '0;
            cnt_q   <= '0;
            oi_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          instr_q <= mem_q[pc_q];
          state_q <= S_ADDR;
        end
        S_ADDR: begin
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          acc_q <= acc_d;
          pc_q  <= pc_q + PW'(1);
          if (is_save) begin
            ov_q  <= 1'b1;
            od_q  <= sat_d;
            oi_q  <= cnt_q;
            cnt_q <= cnt_q + 6'd1;
          end
          if (is_halt) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (&pc_q) begin
            err_q[1] <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_index = oi_q;
  assign busy      = busy_q;
  assign error     = err_q;

endmodule

// File: tb/tb_dsp_sequencer.sv
// Scoreboard bench for dsp_sequencer: directed programs, queued
// expected strobes checked by an independent output monitor.
module tb_dsp_sequencer;

  logic        ck = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic [4:0]  frame_pos = '0;
  logic [7:0]  audio_addr;
  logic [15:0] audio_rdata = '0;
  logic        out_valid;
  logic [15:0] out_data;
  logic [5:0]  out_index;
  logic        busy;
  logic [1:0]  error;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [15:0] sram [256];

  typedef struct {
    logic [15:0] d;
    logic [5:0]  idx;
    int          c;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  localparam logic [6:0] NOOP = 7'b0000000;
  localparam logic [6:0] MAC  = 7'b1000000;
  localparam logic [6:0] MACZ = 7'b1000010;
  localparam logic [6:0] SAVE = 7'b1010000;
  localparam logic [6:0] HALT = 7'b1111111;

  dsp_sequencer_if bus();

  dsp_sequencer dut (
    .ck          (ck),
    .rst         (rst),
    .bus         (bus),
    .frame_start (frame_start),
    .frame_pos   (frame_pos),
    .audio_addr  (audio_addr),
    .audio_rdata (audio_rdata),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_index   (out_index),
    .busy        (busy),
    .error       (error)
  );

  always #5 ck = ~ck;

  always @(posedge ck) cyc <= cyc + 1;

  always @(posedge ck) audio_rdata <= sram[audio_addr];

  always @(negedge ck) begin
    if (out_valid) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL out_unexpected: data=%h idx=%0d cyc=%0d",
                 out_data, out_index, cyc);
      end else begin
        e = sb.pop_front();
        if (out_data !== e.d || out_index !== e.idx || cyc != e.c) begin
          fails++;
          $display("FAIL out_strobe: got %h/%0d@%0d want %h/%0d@%0d",
                   out_data, out_index, cyc, e.d, e.idx, e.c);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ins(logic [6:0] op, logic [4:0] off,
                                      logic [3:0] ch, logic [15:0] g);
    return {op, off, ch, g};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic bus_xfer(input logic [31:0] a, input logic [31:0] wd,
                          input logic wr, output logic ack,
                          output logic [31:0] rd);
    @(posedge ck);
    #1;
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = a;
    bus.iomem_wdata = wd;
    bus.iomem_wstrb = wr ? 4'hF : 4'h0;
    ack = 1'b0;
    rd  = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge ck);
      if (bus.iomem_ready) begin
        ack = 1'b1;
        rd  = bus.iomem_rdata;
        break;
      end
    end
    @(posedge ck);
    #1;
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
  endtask

  task automatic pwr(input int w, input logic [31:0] d);
    logic        ack;
    logic [31:0] rd;
    bus_xfer(32'h6000_0000 | (w << 2), d, 1'b1, ack, rd);
    chk("wr_ack", {31'd0, ack}, 32'd1);
  endtask

  task automatic prd(input int w, output logic [31:0] d);
    logic ack;
    bus_xfer(32'h6000_0000 | (w << 2), 32'd0, 1'b0, ack, d);
    chk("rd_ack", {31'd0, ack}, 32'd1);
  endtask

  task automatic start(input logic [4:0] pos, output int t);
    @(posedge ck);
    #1;
    frame_pos   = pos;
    frame_start = 1'b1;
    t = cyc;
    @(posedge ck);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic at_cyc(input int n);
    while (cyc < n) @(negedge ck);
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    @(posedge ck);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic load_t1();
    pwr(0, ins(MACZ, 5'd4, 4'd1, 16'h2000));
    pwr(1, ins(SAVE, 5'd0, 4'd0, 16'h000F));
    pwr(2, ins(HALT, 5'd0, 4'd0, 16'h0000));
  endtask

  initial begin
    int          t;
    logic        ack;
    logic [31:0] rd;

    for (int i = 0; i < 256; i++) sram[i] = '0;
    sram[38] = 16'h1111;
    sram[64] = 16'h7FFF;
    sram[5]  = 16'h0100;
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
    bus.iomem_addr  = '0;
    bus.iomem_wdata = '0;

    repeat (3) @(posedge ck);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_error", {30'd0, error}, 32'd0);
    chk("rst_index", {26'd0, out_index}, 32'd0);
    chk("rst_data", {16'd0, out_data}, 32'd0);
    chk("rst_ready", {31'd0, bus.iomem_ready}, 32'd0);
    rst = 1'b0;

    pwr(1, 32'h1234_5678);
    prd(1, rd);
    chk("readback", rd, 32'h1234_5678);
    bus_xfer(32'h6100_0004, 32'hFFFF_FFFF, 1'b1, ack, rd);
    chk("miss_noack", {31'd0, ack}, 32'd0);

    for (int w = 0; w < 64; w++) begin
      if (w == 0) pwr(w, ins(MACZ, 5'd0, 4'd0, 16'h0003));
      else if (w == 5) pwr(w, ins(7'h01, 5'd0, 4'd0, 16'h1234));
      else if (w == 10) pwr(w, ins(SAVE, 5'd0, 4'd0, 16'h0000));
      else pwr(w, ins(NOOP, 5'd0, 4'd0, 16'h0000));
    end
    start(5'd5, t);
    sb.push_back('{16'h0300, 6'd0, t + 34});
    at_cyc(t + 20);
    pulse_fs();
    at_cyc(t + 22);
    chk("err_busy_start", {30'd0, error}, 32'd1);
    at_cyc(t + 192);
    chk("runaway_busy", {31'd0, busy}, 32'd1);
    at_cyc(t + 193);
    chk("runaway_idle", {31'd0, busy}, 32'd0);
    chk("runaway_err", {30'd0, error}, 32'd3);
    @(posedge ck);
    #1 rst = 1'b1;
    @(posedge ck);
    #1 rst = 1'b0;
    chk("err_cleared", {30'd0, error}, 32'd0);

    load_t1();
    start(5'd10, t);
    sb.push_back('{16'h0444, 6'd0, t + 7});
    at_cyc(t + 1);
    chk("t1_busy_on", {31'd0, busy}, 32'd1);
    bus_xfer(32'h6000_00FC, 32'hFFFF_FFFF, 1'b1, ack, rd);
    chk("busy_wr_ack", {31'd0, ack}, 32'd1);
    at_cyc(t + 9);
    chk("t1_busy_last", {31'd0, busy}, 32'd1);
    at_cyc(t + 10);
    chk("t1_busy_off", {31'd0, busy}, 32'd0);
    prd(63, rd);
    chk("busy_wr_drop", rd, 32'h0);

    pwr(0, ins(MAC, 5'd5, 4'd1, 16'h0000));
    pwr(1, ins(HALT, 5'd0, 4'd0, 16'h0000));
    start(5'd2, t);
    at_cyc(t + 2);
    chk("addr_wrap", {24'd0, audio_addr}, 32'd61);
    at_cyc(t + 8);

    pwr(0, ins(MACZ, 5'd0, 4'd2, 16'h7FFF));
    pwr(1, ins(MAC, 5'd0, 4'd2, 16'h7FFF));
    pwr(2, ins(SAVE, 5'd0, 4'd0, 16'h000E));
    pwr(3, ins(MACZ, 5'd0, 4'd2, 16'h8000));
    pwr(4, ins(SAVE, 5'd0, 4'd0, 16'h0000));
    pwr(5, ins(HALT, 5'd0, 4'd0, 16'h0000));
    start(5'd0, t);
    sb.push_back('{16'h7FFF, 6'd0, t + 10});
    sb.push_back('{16'h8000, 6'd1, t + 16});
    at_cyc(t + 19);
    chk("t3_busy_off", {31'd0, busy}, 32'd0);

    load_t1();
    start(5'd10, t);
    at_cyc(t + 2);
    pulse_fs();
    chk("t6_err0", {30'd0, error}, 32'd1);
    at_cyc(t + 5);
    rst = 1'b1;
    @(posedge ck);
    #1 rst = 1'b0;
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_error", {30'd0, error}, 32'd0);
    start(5'd10, t);
    sb.push_back('{16'h0444, 6'd0, t + 7});
    at_cyc(t + 12);

    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
